uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampled UART receiver: majority-voted bits, optional parity, and early return to idle
// at the stop-bit decision so that back-to-back frames lose no cycle.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned EW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] EDGE_S0   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] EDGE_S1   = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] EDGE_VOTE = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state_q;
    logic [EW-1:0]           edge_q;
    logic [BW-1:0]           bit_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    samp0_q;
    logic                    samp1_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_fail_q;

    logic vote;
    logic at_vote;
    logic bit_done;
    logic exp_par;

    // The third vote sample is the live input, so the decision lands on EDGE_VOTE itself.
    assign vote     = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);
    assign at_vote  = (edge_q == EDGE_VOTE);
    assign bit_done = (edge_q == EDGE_LAST);
    assign exp_par  = (^shift_q) ^ par_typ_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            samp0_q    <= 1'b0;
            samp1_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state_q != StIdle) begin
                edge_q <= bit_done ? '0 : edge_q + 1'b1;
                if (edge_q == EDGE_S0) samp0_q <= RX_IN;
                if (edge_q == EDGE_S1) samp1_q <= RX_IN;
            end

            case (state_q)
                StIdle: begin
                    // The detection cycle counts as edge 0 of the start bit.
                    if (!RX_IN) begin
                        state_q    <= StStart;
                        edge_q     <= EW'(1);
                        bit_q      <= '0;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_fail_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_vote && vote) begin
                        state_q <= StIdle;
                        edge_q  <= '0;
                    end else if (bit_done) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (at_vote) shift_q[bit_q] <= vote;
                    if (bit_done) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (at_vote) par_fail_q <= (vote != exp_par);
                    if (bit_done) state_q <= StStop;
                end
                StStop: begin
                    if (at_vote) begin
                        STP_ERR    <= ~vote;
                        PAR_ERR    <= par_fail_q;
                        DATA_VALID <= vote & ~par_fail_q;
                        if (vote && !par_fail_q) P_DATA <= shift_q;
                        state_q <= StIdle;
                        edge_q  <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    edge_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed-frame bench for uart_rx: the driver pushes hand-computed expectations into a
// scoreboard queue, and a negedge monitor pops one entry for every output pulse.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t sb[$];

    uart_rx #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_IN     (rx_in),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .PAR_ERR   (par_err),
        .STP_ERR   (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endfunction

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got dv=%b pe=%b se=%b at cycle %0d expected none",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cycle);
                check("data_valid", {31'b0, data_valid}, {31'b0, e.dv});
                check("par_err", {31'b0, par_err}, {31'b0, e.pe});
                check("stp_err", {31'b0, stp_err}, {31'b0, e.se});
                check("p_data", {24'b0, p_data}, {24'b0, e.data});
            end
        end
    end

    task automatic drive(input logic v);
        @(posedge clk);
        #1;
        rx_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // rst_at >= 0 pulses RST during that cycle offset from t0; no expectation is pushed then.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, input bit flip,
                              input int rst_at, input bit edv, input bit epe,
                              input bit ese, input logic [7:0] edata);
        logic bits[$];
        logic v;
        int   t0;
        int   lat;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(sbit);
        lat = pen ? 86 : 78;
        par_en  = pen;
        par_typ = ptyp;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < 8; c++) begin
                v = bits[b];
                if (flip && b >= 1 && b <= 8 && c == 3 + ((b - 1) % 3)) v = ~v;
                @(posedge clk);
                #1;
                rx_in = v;
                rst   = (b * 8 + c == rst_at);
                if (b == 0 && c == 0) begin
                    t0 = cyc;
                    if (rst_at < 0) sb.push_back('{edv, epe, ese, edata, t0 + lat});
                end
                // Frame config must be latched at start detection, so disturb it afterwards.
                if (b == 1 && c == 0) begin
                    par_en  = ~pen;
                    par_typ = ~ptyp;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rx_in   = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p_data", {24'b0, p_data}, 32'h0);
        check("reset_data_valid", {31'b0, data_valid}, 32'h0);
        check("reset_par_err", {31'b0, par_err}, 32'h0);
        check("reset_stp_err", {31'b0, stp_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // 0xA5 even parity (four ones -> parity 0)
        send_frame(8'hA5, 1, 0, 0, 1, 0, -1, 1, 0, 0, 8'hA5);
        idle(4);
        // 0x3C no parity, then 0xFF back-to-back
        send_frame(8'h3C, 0, 0, 0, 1, 0, -1, 1, 0, 0, 8'h3C);
        send_frame(8'hFF, 0, 0, 0, 1, 0, -1, 1, 0, 0, 8'hFF);
        idle(4);
        // 0x01 odd parity: correct bit is 0
        send_frame(8'h01, 1, 1, 1, 1, 0, -1, 0, 1, 0, 8'hFF);
        idle(4);
        send_frame(8'h01, 1, 1, 0, 0, 0, -1, 0, 0, 1, 8'hFF);
        idle(12);
        send_frame(8'h01, 1, 1, 1, 0, 0, -1, 0, 1, 1, 8'hFF);
        idle(12);
        // Two-cycle glitch; a real frame starting at glitch+6 proves the return to idle
        drive(1'b0);
        drive(1'b0);
        idle(4);
        send_frame(8'h96, 1, 1, 1, 1, 0, -1, 1, 0, 0, 8'h96);
        idle(4);
        // Reset at t0+40 aborts 0xF5; tail bits are all ones so nothing restarts
        send_frame(8'hF5, 0, 0, 0, 1, 0, 40, 0, 0, 0, 8'h00);
        idle(4);
        send_frame(8'h5A, 0, 0, 0, 1, 0, -1, 1, 0, 0, 8'h5A);
        idle(4);
        // One vote sample flipped in every data bit
        send_frame(8'hC3, 1, 0, 0, 1, 1, -1, 1, 0, 0, 8'hC3);
        idle(20);

        check("pending_expectations", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
